// File: rtl/ts_cc_monitor.sv
// Multi-channel MPEG-TS continuity-counter checker: passive tap on the 32-bit TS word bus.
// Captures each header, evaluates CC continuity once per packet at word 1, per-PID channel.
module ts_cc_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             ts_din,
  input  logic                    ts_din_en,
  input  logic [NUM_CH*13-1:0]    pid_cfg,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    clr,
  output logic [NUM_CH-1:0]       err_flag,
  output logic [NUM_CH-1:0]       err_pulse,
  output logic [NUM_CH*CNT_W-1:0] err_cnt,
  output logic                    sync_err
);

  logic [7:0]  r_word_cnt;
  logic [12:0] r_pid;
  logic        r_tei;
  logic [1:0]  r_afc;
  logic [3:0]  r_cc;
  logic        r_hdr_ok;
  logic        r_sync_err;

  logic w_hdr;
  logic w_eval;
  logic w_disc;
  logic w_unused;

  assign w_hdr    = ts_din_en && (r_word_cnt == 8'd0);
  assign w_eval   = ts_din_en && (r_word_cnt == 8'd1) && r_hdr_ok;
  // Discontinuity only counts when an adaptation field exists and is non-empty.
  assign w_disc   = r_afc[1] && (ts_din[31:24] != 8'd0) && ts_din[23];
  assign w_unused = ^{ts_din[22:21], ts_din[7:6]};
  assign sync_err = r_sync_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word_cnt <= 8'd0;
      r_pid      <= 13'd0;
      r_tei      <= 1'b0;
      r_afc      <= 2'b00;
      r_cc       <= 4'd0;
      r_hdr_ok   <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= 1'b0;
      if (!ts_din_en)
        r_word_cnt <= 8'd0;
      else if (r_word_cnt != 8'hFF)
        r_word_cnt <= r_word_cnt + 8'd1;
      if (w_hdr) begin
        r_pid      <= ts_din[20:8];
        r_tei      <= ts_din[23];
        r_afc      <= ts_din[5:4];
        r_cc       <= ts_din[3:0];
        r_hdr_ok   <= (ts_din[31:24] == 8'h47);
        r_sync_err <= (ts_din[31:24] != 8'h47);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic             r_valid;
    logic             r_dup;
    logic [3:0]       r_last_cc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;
    logic             r_pulse;
    logic             w_part;
    logic [3:0]       w_next_cc;

    assign w_part    = w_eval && ch_en[g] && (r_pid == pid_cfg[13*g +: 13])
                       && !r_tei && r_afc[0];
    assign w_next_cc = r_last_cc + 4'd1;

    // NOTE: per-channel learned state is a handful of flops, so it is reset
    // explicitly; the first packet after reset must see valid=0.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_valid   <= 1'b0;
        r_dup     <= 1'b0;
        r_last_cc <= 4'd0;
        r_cnt     <= '0;
        r_flag    <= 1'b0;
        r_pulse   <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        if (clr) begin
          r_cnt   <= '0;
          r_flag  <= 1'b0;
          r_valid <= 1'b0;
          r_dup   <= 1'b0;
        end else if (!ch_en[g]) begin
          r_valid <= 1'b0;
        end else if (w_part) begin
          if (!r_valid || w_disc || (r_cc == w_next_cc)) begin
            r_last_cc <= r_cc;
            r_valid   <= 1'b1;
            r_dup     <= 1'b0;
          end else if ((r_cc == r_last_cc) && !r_dup) begin
            r_dup <= 1'b1;
          end else begin
            r_pulse   <= 1'b1;
            r_flag    <= 1'b1;
            if (r_cnt != {CNT_W{1'b1}})
              r_cnt <= r_cnt + CNT_W'(1);
            r_last_cc <= r_cc;
            r_dup     <= 1'b0;
          end
        end
      end
    end

    assign err_cnt[CNT_W*g +: CNT_W] = r_cnt;
    assign err_flag[g]               = r_flag;
    assign err_pulse[g]              = r_pulse;
  end

endmodule
